// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the codec configuration write arbiter.
// The optional init-first masking is selected with CODEC_ARB_INIT_FIRST_EN.
package codec_cfg_pkg;

   localparam int WORD_W  = 16;
   localparam int FRAME_W = 24;
   localparam logic [7:0] CODEC_DEV_ADDR = 8'h34;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_START,
      ST_WAIT_END,
      ST_CHECK,
      ST_GAP,
      ST_COOL
   } cfg_state_e;

endpackage

// File: rtl/codec_cfg_rr_pick.sv
// Combinational round-robin selector: the first masked request at or after
// ptr_i wins, returned both one-hot and as an index.
module codec_cfg_rr_pick #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [NUM_REQ-1:0] mask_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               vld_o
);

   logic [NUM_REQ-1:0] req_m;
   int                 cand;

   assign req_m = req_i & mask_i;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      cand  = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(ptr_i) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!vld_o && req_m[cand[IDX_W-1:0]]) begin
            vld_o                   = 1'b1;
            gnt_o[cand[IDX_W-1:0]]  = 1'b1;
            idx_o                   = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/codec_cfg_arbiter.sv
// Arbitrates codec register writes from NUM_REQ requesters onto one I2C write
// engine, with retry, watchdog and inter-frame gap. Optional macro
// CODEC_ARB_INIT_FIRST_EN masks requesters 1.. until requester 0 gets a DONE.
//
// state      | meaning
// IDLE       | pick a requester, latch its word
// ISSUE      | raise GO, arm watchdog
// WAIT_START | wait for the engine to drop END
// WAIT_END   | wait for END to return, sample NACK
// CHECK      | drop GO, decide DONE / retry / ERR
// GAP        | hold GO low between frames
// COOL       | one idle cycle before re-arbitration
module codec_cfg_arbiter
   import codec_cfg_pkg::*;
#(
   parameter int         NUM_REQ     = 3,
   parameter logic [7:0] DEV_ADDR    = CODEC_DEV_ADDR,
   parameter int         MAX_RETRY   = 3,
   parameter int         GAP_CYC     = 4096,
   parameter int         TIMEOUT_CYC = 1 << 20
) (
   input  logic                      CLOCK_27,
   input  logic                      RESET,
   input  logic [NUM_REQ-1:0]        REQ,
   input  logic [WORD_W*NUM_REQ-1:0] REQ_DATA,
   output logic [NUM_REQ-1:0]        GNT,
   output logic [NUM_REQ-1:0]        DONE,
   output logic [NUM_REQ-1:0]        ERR,
   output logic [FRAME_W-1:0]        I2C_DATA,
   output logic                      I2C_GO,
   input  logic                      I2C_END,
   input  logic                      I2C_NACK,
   output logic                      BUSY
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam int GAP_W = $clog2(GAP_CYC + 1);
   localparam int RTY_W = $clog2(MAX_RETRY + 1);

   cfg_state_e          state_q;
   logic [NUM_REQ-1:0]  sel_q;
   logic [IDX_W-1:0]    ptr_q;
   logic [RTY_W-1:0]    retry_q;
   logic                retry_flag_q;
   logic                nack_q;
   logic [TMR_W-1:0]    timer_q;
   logic [GAP_W-1:0]    gap_q;
   logic [NUM_REQ-1:0]  gnt_q;
   logic [NUM_REQ-1:0]  done_q;
   logic [NUM_REQ-1:0]  err_q;
   logic [FRAME_W-1:0]  data_q;
   logic                go_q;
   logic                end_s1_q;
   logic                end_s2_q;
   logic                nack_s1_q;
   logic                nack_s2_q;

   logic [NUM_REQ-1:0]  req_mask;
   logic [NUM_REQ-1:0]  win_gnt;
   logic [IDX_W-1:0]    win_idx;
   logic                win_vld;
   logic [WORD_W-1:0]   win_word;
   logic                tmr_tc;
   logic                gap_tc;

`ifdef CODEC_ARB_INIT_FIRST_EN
   logic init_done_q;

   always_ff @(posedge CLOCK_27) begin
      if (RESET) begin
         init_done_q <= 1'b0;
      end else if (state_q == ST_CHECK && !nack_q && sel_q[0]) begin
         init_done_q <= 1'b1;
      end
   end

   assign req_mask = init_done_q ? '1 : NUM_REQ'(1);
`else
   assign req_mask = '1;
`endif

   codec_cfg_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req_i  (REQ),
      .mask_i (req_mask),
      .ptr_i  (ptr_q),
      .gnt_o  (win_gnt),
      .idx_o  (win_idx),
      .vld_o  (win_vld)
   );

   always_comb begin
      win_word = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win_idx == IDX_W'(k)) win_word = REQ_DATA[k*WORD_W +: WORD_W];
      end
   end

   // Down-counters fire on the last cycle of their window.
   assign tmr_tc = (timer_q <= TMR_W'(1));
   assign gap_tc = (gap_q <= GAP_W'(1));

   always_ff @(posedge CLOCK_27) begin
      if (RESET) begin
         state_q      <= ST_IDLE;
         sel_q        <= '0;
         ptr_q        <= '0;
         retry_q      <= '0;
         retry_flag_q <= 1'b0;
         nack_q       <= 1'b0;
         timer_q      <= '0;
         gap_q        <= '0;
         gnt_q        <= '0;
         done_q       <= '0;
         err_q        <= '0;
         data_q       <= '0;
         go_q         <= 1'b0;
         end_s1_q     <= 1'b0;
         end_s2_q     <= 1'b0;
         nack_s1_q    <= 1'b0;
         nack_s2_q    <= 1'b0;
      end else begin
         end_s1_q  <= I2C_END;
         end_s2_q  <= end_s1_q;
         nack_s1_q <= I2C_NACK;
         nack_s2_q <= nack_s1_q;
         gnt_q     <= '0;
         done_q    <= '0;
         err_q     <= '0;

         unique case (state_q)
            ST_IDLE: begin
               if (win_vld) begin
                  gnt_q        <= win_gnt;
                  sel_q        <= win_gnt;
                  data_q       <= {DEV_ADDR, win_word};
                  retry_q      <= '0;
                  retry_flag_q <= 1'b0;
                  ptr_q        <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                  state_q      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               go_q    <= 1'b1;
               timer_q <= TMR_W'(TIMEOUT_CYC);
               state_q <= ST_WAIT_START;
            end
            ST_WAIT_START: begin
               if (!tmr_tc) timer_q <= timer_q - 1'b1;
               if (!end_s2_q) begin
                  state_q <= ST_WAIT_END;
               end else if (tmr_tc) begin
                  nack_q  <= 1'b1;
                  state_q <= ST_CHECK;
               end
            end
            ST_WAIT_END: begin
               if (!tmr_tc) timer_q <= timer_q - 1'b1;
               if (end_s2_q) begin
                  nack_q  <= nack_s2_q;
                  state_q <= ST_CHECK;
               end else if (tmr_tc) begin
                  nack_q  <= 1'b1;
                  state_q <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               go_q    <= 1'b0;
               gap_q   <= GAP_W'(GAP_CYC);
               state_q <= ST_GAP;
               if (!nack_q) begin
                  done_q       <= sel_q;
                  retry_flag_q <= 1'b0;
               end else if (retry_q < RTY_W'(MAX_RETRY)) begin
                  retry_q      <= retry_q + 1'b1;
                  retry_flag_q <= 1'b1;
               end else begin
                  err_q        <= sel_q;
                  retry_flag_q <= 1'b0;
               end
            end
            ST_GAP: begin
               if (gap_tc) begin
                  state_q <= retry_flag_q ? ST_ISSUE : ST_COOL;
               end else begin
                  gap_q <= gap_q - 1'b1;
               end
            end
            ST_COOL: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign GNT      = gnt_q;
   assign DONE     = done_q;
   assign ERR      = err_q;
   assign I2C_DATA = data_q;
   assign I2C_GO   = go_q;
   assign BUSY     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_codec_cfg_arbiter.sv
// Directed bench for codec_cfg_arbiter with a behavioural I2C engine model.
// Build with CODEC_ARB_INIT_FIRST_EN defined to exercise init-first masking.
module tb_codec_cfg_arbiter;

   localparam int GAP = 8;
   localparam int TMO = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req = '0;
   logic [47:0] req_data = '0;
   logic [2:0]  gnt, done, err;
   logic [23:0] i2c_data;
   logic        go;
   logic        i2c_end = 1'b1;
   logic        i2c_nack = 1'b0;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;

   codec_cfg_arbiter #(
      .NUM_REQ     (3),
      .DEV_ADDR    (8'h34),
      .MAX_RETRY   (3),
      .GAP_CYC     (GAP),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .CLOCK_27 (clk),
      .RESET    (rst),
      .REQ      (req),
      .REQ_DATA (req_data),
      .GNT      (gnt),
      .DONE     (done),
      .ERR      (err),
      .I2C_DATA (i2c_data),
      .I2C_GO   (go),
      .I2C_END  (i2c_end),
      .I2C_NACK (i2c_nack),
      .BUSY     (busy)
   );

   always #5 clk = ~clk;

   // Engine model: END drops 3 cycles after GO rises, returns 6 cycles later.
   logic stuck = 1'b0;
   int   nack_plan = 0;
   int   nack_base = 0;
   int   eng_done_cnt = 0;
   int   eng_cnt = 0;
   logic eng_go_prev = 1'b0;

   always @(negedge clk) begin
      if (go && !eng_go_prev) eng_cnt = 1;
      else if (eng_cnt != 0) eng_cnt++;
      if (eng_cnt == 3 && !stuck) begin
         i2c_end  = 1'b0;
         i2c_nack = 1'b0;
      end
      if (eng_cnt == 9) begin
         if (!stuck) begin
            i2c_nack = ((eng_done_cnt - nack_base) < nack_plan);
            i2c_end  = 1'b1;
         end
         eng_done_cnt++;
         eng_cnt = 0;
      end
      eng_go_prev = go;
   end

   // Passive monitor: GO edges, frame words, grants, pulses, low gaps.
   int          go_rises = 0;
   int          done_tot = 0;
   int          err_tot = 0;
   int          onehot_bad = 0;
   int          low_run = 0;
   logic        seen_fall = 1'b0;
   logic        mon_go_prev = 1'b0;
   int          gnt_log[$];
   logic [23:0] go_data[$];
   int          low_log[$];

   always @(negedge clk) begin
      if (go && !mon_go_prev) begin
         go_rises++;
         go_data.push_back(i2c_data);
         if (seen_fall) low_log.push_back(low_run);
      end
      if (!go && mon_go_prev) begin
         seen_fall = 1'b1;
         low_run   = 0;
      end
      if (!go) low_run++;
      if ($countones(gnt) > 1 || $countones(done) > 1 || $countones(err) > 1) onehot_bad++;
      for (int i = 0; i < 3; i++) if (gnt[i]) gnt_log.push_back(i);
      if (done != 0) done_tot++;
      if (err != 0) err_tot++;
      mon_go_prev = go;
   end

   int b_rises, b_done, b_err, b_gnt, b_data, b_low, b_bad;

   task automatic snap();
      b_rises = go_rises;
      b_done  = done_tot;
      b_err   = err_tot;
      b_gnt   = gnt_log.size();
      b_data  = go_data.size();
      b_low   = low_log.size();
      b_bad   = onehot_bad;
   endtask

   task automatic set_nack(input int n);
      nack_plan = n;
      nack_base = eng_done_cnt;
   endtask

   task automatic wait_pulse(input int budget, input string name);
      int n = 0;
      while (done == 0 && err == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (done == 0 && err == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_wait: no DONE/ERR within %0d cycles", name, budget);
      end
   endtask

   task automatic wait_gnt(input int budget, input string name);
      int n = 0;
      while (gnt == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (gnt == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_gnt_wait: no GNT within %0d cycles", name, budget);
      end
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_idle: BUSY got %b want 0", name, busy);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic apply_reset(input bit unlock);
      req   = '0;
      stuck = 1'b0;
      set_nack(0);
      repeat (12) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
`ifdef CODEC_ARB_INIT_FIRST_EN
      if (unlock) begin
         req = 3'b001;
         wait_pulse(200, "unlock");
         @(negedge clk);
         req = '0;
         wait_idle(50, "unlock");
      end
`else
      if (unlock) @(negedge clk);
`endif
      snap();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 3'b111;
      repeat (3) @(negedge clk);
      vectors++; if (gnt !== 3'b000) begin miscompares++; $display("FAIL rst_gnt: got %b want 000", gnt); end
      vectors++; if (done !== 3'b000) begin miscompares++; $display("FAIL rst_done: got %b want 000", done); end
      vectors++; if (err !== 3'b000) begin miscompares++; $display("FAIL rst_err: got %b want 000", err); end
      vectors++; if (go !== 1'b0) begin miscompares++; $display("FAIL rst_go: got %b want 0", go); end
      vectors++; if (i2c_data !== 24'h0) begin miscompares++; $display("FAIL rst_data: got %h want 000000", i2c_data); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
      req = '0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      apply_reset(1);
      req_data[31:16] = 16'h047B;
      req = 3'b010;
      wait_gnt(20, "single");
      vectors++; if (gnt !== 3'b010) begin miscompares++; $display("FAIL single_gnt: got %b want 010", gnt); end
      vectors++; if (i2c_data !== 24'h34047B) begin miscompares++; $display("FAIL single_data: got %h want 34047b", i2c_data); end
      @(negedge clk);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b want 1", busy); end
      wait_pulse(200, "single");
      vectors++; if (done !== 3'b010) begin miscompares++; $display("FAIL single_done: got %b want 010", done); end
      vectors++; if (err !== 3'b000) begin miscompares++; $display("FAIL single_err: got %b want 000", err); end
      @(negedge clk);
      req = '0;
      wait_idle(50, "single");
      vectors++; if (go_rises - b_rises != 1) begin miscompares++; $display("FAIL single_frames: got %0d want 1", go_rises - b_rises); end
   endtask

   task automatic test_round_robin();
      int start;
      int n = 0;
`ifdef CODEC_ARB_INIT_FIRST_EN
      start = 1;
`else
      start = 0;
`endif
      apply_reset(1);
      req_data = {16'h3333, 16'h2222, 16'h1111};
      req = 3'b111;
      while (gnt_log.size() - b_gnt < 4 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      wait_pulse(200, "rr");
      @(negedge clk);
      req = '0;
      wait_idle(50, "rr");
      vectors++;
      if (gnt_log.size() - b_gnt != 4) begin
         miscompares++;
         $display("FAIL rr_count: got %0d grants want 4", gnt_log.size() - b_gnt);
      end else begin
         for (int k = 0; k < 4; k++) begin
            int exp_i = (start + k) % 3;
            vectors++;
            if (gnt_log[b_gnt + k] != exp_i) begin
               miscompares++;
               $display("FAIL rr_order[%0d]: got %0d want %0d", k, gnt_log[b_gnt + k], exp_i);
            end
            vectors++;
            if (go_data[b_data + k] !== {8'h34, req_data[exp_i*16 +: 16]}) begin
               miscompares++;
               $display("FAIL rr_data[%0d]: got %h want %h", k, go_data[b_data + k], {8'h34, req_data[exp_i*16 +: 16]});
            end
         end
      end
      vectors++; if (go_rises - b_rises != 4) begin miscompares++; $display("FAIL rr_frames: got %0d want 4", go_rises - b_rises); end
      vectors++; if (done_tot - b_done != 4) begin miscompares++; $display("FAIL rr_dones: got %0d want 4", done_tot - b_done); end
      vectors++; if (onehot_bad != b_bad) begin miscompares++; $display("FAIL rr_onehot: got %0d violations want 0", onehot_bad - b_bad); end
      for (int k = b_low; k < low_log.size(); k++) begin
         vectors++;
         if (low_log[k] < GAP) begin
            miscompares++;
            $display("FAIL rr_gap: got %0d low cycles want >= %0d", low_log[k], GAP);
         end
      end
   endtask

   task automatic test_retry_ok();
      apply_reset(1);
      set_nack(2);
      req_data[15:0] = 16'h1201;
      req = 3'b001;
      wait_pulse(400, "retry");
      vectors++; if (done !== 3'b001) begin miscompares++; $display("FAIL retry_done: got %b want 001", done); end
      vectors++; if (err !== 3'b000) begin miscompares++; $display("FAIL retry_err: got %b want 000", err); end
      @(negedge clk);
      req = '0;
      wait_idle(50, "retry");
      vectors++; if (go_rises - b_rises != 3) begin miscompares++; $display("FAIL retry_attempts: got %0d want 3", go_rises - b_rises); end
      for (int k = b_data; k < go_data.size(); k++) begin
         vectors++;
         if (go_data[k] !== 24'h341201) begin miscompares++; $display("FAIL retry_data: got %h want 341201", go_data[k]); end
      end
      vectors++; if (err_tot != b_err) begin miscompares++; $display("FAIL retry_no_err: got %0d ERR pulses want 0", err_tot - b_err); end
      for (int k = b_low; k < low_log.size(); k++) begin
         vectors++;
         if (low_log[k] < GAP) begin miscompares++; $display("FAIL retry_gap: got %0d low cycles want >= %0d", low_log[k], GAP); end
      end
   endtask

   task automatic test_nack_err();
      apply_reset(1);
      set_nack(1000);
      req_data[47:32] = 16'h5A5A;
      req = 3'b100;
      wait_pulse(600, "nack");
      vectors++; if (err !== 3'b100) begin miscompares++; $display("FAIL nack_err: got %b want 100", err); end
      vectors++; if (done !== 3'b000) begin miscompares++; $display("FAIL nack_done: got %b want 000", done); end
      @(negedge clk);
      req = '0;
      wait_idle(50, "nack");
      vectors++; if (go_rises - b_rises != 4) begin miscompares++; $display("FAIL nack_attempts: got %0d want 4", go_rises - b_rises); end
      vectors++; if (done_tot != b_done) begin miscompares++; $display("FAIL nack_no_done: got %0d DONE pulses want 0", done_tot - b_done); end
      set_nack(0);
      req_data[31:16] = 16'h0C0C;
      req = 3'b010;
      wait_gnt(20, "nack_next");
      vectors++; if (i2c_data !== 24'h340C0C) begin miscompares++; $display("FAIL nack_next_data: got %h want 340c0c", i2c_data); end
      wait_pulse(200, "nack_next");
      vectors++; if (done !== 3'b010) begin miscompares++; $display("FAIL nack_next_done: got %b want 010", done); end
      @(negedge clk);
      req = '0;
      wait_idle(50, "nack_next");
   endtask

   task automatic test_timeout();
      apply_reset(1);
      stuck = 1'b1;
      req = 3'b001;
      wait_pulse(2000, "tmo");
      vectors++; if (err !== 3'b001) begin miscompares++; $display("FAIL tmo_err: got %b want 001", err); end
      @(negedge clk);
      req = '0;
      wait_idle(50, "tmo");
      vectors++; if (go_rises - b_rises != 4) begin miscompares++; $display("FAIL tmo_attempts: got %0d want 4", go_rises - b_rises); end
      vectors++; if (done_tot != b_done) begin miscompares++; $display("FAIL tmo_no_done: got %0d DONE pulses want 0", done_tot - b_done); end
      stuck = 1'b0;
   endtask

   task automatic test_reset_mid();
      int n = 0;
      apply_reset(1);
      req_data[15:0] = 16'hBEEF;
      req = 3'b001;
      while (!(go && !i2c_end) && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      vectors++; if (go !== 1'b1) begin miscompares++; $display("FAIL rmid_pre_go: got %b want 1", go); end
      rst = 1'b1;
      @(negedge clk);
      vectors++; if (go !== 1'b0) begin miscompares++; $display("FAIL rmid_go: got %b want 0", go); end
      vectors++; if (i2c_data !== 24'h0) begin miscompares++; $display("FAIL rmid_data: got %h want 000000", i2c_data); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b want 0", busy); end
      vectors++; if ({gnt, done, err} !== 9'b0) begin miscompares++; $display("FAIL rmid_pulses: got %b want 0", {gnt, done, err}); end
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      vectors++; if (done_tot != b_done || err_tot != b_err) begin miscompares++; $display("FAIL rmid_no_result: got %0d DONE %0d ERR want 0 0", done_tot - b_done, err_tot - b_err); end
   endtask

   task automatic test_init_first();
      apply_reset(0);
      req_data = {16'h3333, 16'h2222, 16'h1111};
      req = 3'b110;
`ifdef CODEC_ARB_INIT_FIRST_EN
      repeat (40) @(negedge clk);
      vectors++; if (gnt_log.size() != b_gnt) begin miscompares++; $display("FAIL init_masked: got %0d grants want 0", gnt_log.size() - b_gnt); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL init_busy: got %b want 0", busy); end
      req = 3'b111;
      wait_gnt(20, "init0");
      vectors++; if (gnt !== 3'b001) begin miscompares++; $display("FAIL init_gnt0: got %b want 001", gnt); end
      wait_pulse(200, "init0");
      vectors++; if (done !== 3'b001) begin miscompares++; $display("FAIL init_done0: got %b want 001", done); end
      @(negedge clk);
      req = 3'b110;
      wait_gnt(100, "init1");
      vectors++; if (gnt !== 3'b010) begin miscompares++; $display("FAIL init_gnt1: got %b want 010", gnt); end
`else
      wait_gnt(20, "nomask");
      vectors++; if (gnt !== 3'b010) begin miscompares++; $display("FAIL nomask_gnt: got %b want 010", gnt); end
`endif
      wait_pulse(200, "init_tail");
      @(negedge clk);
      req = '0;
      wait_idle(50, "init_tail");
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_retry_ok();
      test_nack_err();
      test_timeout();
      test_reset_mid();
      test_init_first();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
